// File: rtl/e7_resp_pkg.sv
// Shared widths, MISR tap placement and the capture FIFO entry layout for the e7 response capture block.
package e7_resp_pkg;

    localparam int unsigned E7_WORD_W  = 20;
    localparam int unsigned E7_DEPTH   = 4;
    localparam int unsigned E7_STAMP_W = 8;

    // Second MISR feedback tap sits this many bits below the MSB (x^20+x^17+1 at 20 bits).
    localparam int unsigned E7_MISR_TAP_BACK = 3;

    typedef struct packed {
        logic [E7_STAMP_W-1:0] stamp;
        logic [E7_WORD_W-1:0]  word;
    } e7_entry_t;

endpackage

// File: rtl/e7_resp_fifo.sv
// First-word-fall-through capture FIFO holding {stamp, word} entries; drops pushes when full
// (unless a pop happens on the same edge) and raises a sticky overflow flag.
module e7_resp_fifo
    import e7_resp_pkg::*;
#(
    parameter int unsigned WORD_W  = E7_WORD_W,
    parameter int unsigned STAMP_W = E7_STAMP_W,
    parameter int unsigned DEPTH   = E7_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [STAMP_W-1:0] push_stamp,
    input  logic [WORD_W-1:0]  push_word,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_data,
    output logic [STAMP_W-1:0] out_stamp,
    output logic               overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = STAMP_W + WORD_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               pop;
    logic               wr_en;

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop on the same edge frees the head slot, so a push into a full FIFO still lands.
    assign wr_en     = push & (~full | pop);

    assign {out_stamp, out_data} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {push_stamp, push_word};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count <= count - CNT_W'(1);
            end
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/e7_resp_capture.sv
// Captures changes on the upstream FSM output word with a cycle time-stamp into a small FIFO.
// Optional output signature (MISR) enabled by defining E7_RESP_MISR_EN; otherwise sig is tied to 0.
module e7_resp_capture
    import e7_resp_pkg::*;
#(
    parameter int unsigned WORD_W  = E7_WORD_W,
    parameter int unsigned DEPTH   = E7_DEPTH,
    parameter int unsigned STAMP_W = E7_STAMP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  y_in,
    input  logic               sample_en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_data,
    output logic [STAMP_W-1:0] out_stamp,
    output logic [WORD_W-1:0]  sig,
    output logic               overflow
);

    logic [STAMP_W-1:0] stamp_cnt;
    logic [WORD_W-1:0]  last_word;
    logic               first_flag;
    logic               push;

    // The first sample after reset always records, later ones only on a change.
    assign push = sample_en & (first_flag | (y_in != last_word));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stamp_cnt  <= '0;
            last_word  <= '0;
            first_flag <= 1'b1;
        end else begin
            stamp_cnt <= stamp_cnt + STAMP_W'(1);
            if (sample_en) begin
                last_word  <= y_in;
                first_flag <= 1'b0;
            end
        end
    end

`ifdef E7_RESP_MISR_EN
    localparam int unsigned TAP = WORD_W - 1 - E7_MISR_TAP_BACK;

    logic [WORD_W-1:0] misr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misr <= '0;
        end else if (sample_en) begin
            misr <= {misr[WORD_W-2:0], misr[WORD_W-1] ^ misr[TAP]} ^ y_in;
        end
    end

    assign sig = misr;
`else
    assign sig = '0;
`endif

    e7_resp_fifo #(
        .WORD_W  (WORD_W),
        .STAMP_W (STAMP_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_stamp (stamp_cnt),
        .push_word  (y_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_stamp  (out_stamp),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_e7_resp_capture.sv
// Directed bench for e7_resp_capture: a vector table for the basic capture/FIFO flow plus
// hand sequences for mid-run reset, full push+pop and the output signature.
module tb_e7_resp_capture;
    import e7_resp_pkg::*;

    localparam int unsigned W  = E7_WORD_W;
    localparam int unsigned S  = E7_STAMP_W;
    localparam int unsigned NV = 17;

    typedef struct {
        logic      en;
        logic [W-1:0] y;
        logic      rdy;
        logic      valid;
        e7_entry_t head;
        logic      ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] y_in = '0;
    logic         sample_en = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [S-1:0] out_stamp;
    logic [W-1:0] sig;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_sig = '0;
    vec_t vecs [NV];

    e7_resp_capture dut (
        .clk       (clk),
        .rst       (rst),
        .y_in      (y_in),
        .sample_en (sample_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .sig       (sig),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs (called just after a falling edge), take one rising edge, land on the next falling edge.
    task automatic step(input logic en, input logic [W-1:0] y, input logic rdy);
        sample_en = en;
        y_in      = y;
        out_ready = rdy;
        @(posedge clk);
`ifdef E7_RESP_MISR_EN
        if (en) exp_sig = {exp_sig[W-2:0], exp_sig[W-1] ^ exp_sig[W-4]} ^ y;
`endif
        @(negedge clk);
        check("sig", 32'(sig), 32'(exp_sig));
    endtask

    task automatic check_head(input string n, input logic v, input e7_entry_t h, input logic o);
        check({n, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({n, "_data"}, 32'(out_data), 32'(h.word));
            check({n, "_stamp"}, 32'(out_stamp), 32'(h.stamp));
        end
        check({n, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    function automatic e7_entry_t ent(input logic [S-1:0] st, input logic [W-1:0] d);
        e7_entry_t e;
        e.stamp = st;
        e.word  = d;
        return e;
    endfunction

    function automatic vec_t mk(input logic en, input logic [W-1:0] y, input logic rdy,
                                input logic valid, input logic [S-1:0] st,
                                input logic [W-1:0] d, input logic ovf);
        vec_t v;
        v.en    = en;
        v.y     = y;
        v.rdy   = rdy;
        v.valid = valid;
        v.head  = ent(st, d);
        v.ovf   = ovf;
        return v;
    endfunction

    // Async reset pulse between edges; the edge after release is idle, so the next sample sees stamp 1.
    task automatic do_reset(input string n);
        sample_en = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check({n, "_valid"}, 32'(out_valid), 32'd0);
        check({n, "_data"}, 32'(out_data), 32'd0);
        check({n, "_stamp"}, 32'(out_stamp), 32'd0);
        check({n, "_ovf"}, 32'(overflow), 32'd0);
        check({n, "_sig"}, 32'(sig), 32'd0);
        exp_sig = '0;
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Stamp counts edges since reset release; vector 0 is the idle edge taking it to 1.
        vecs[0]  = mk(1'b0, 20'h00000, 1'b0, 1'b0, 8'd0,  20'h00000, 1'b0);
        vecs[1]  = mk(1'b1, 20'h00000, 1'b0, 1'b1, 8'd1,  20'h00000, 1'b0);
        vecs[2]  = mk(1'b0, 20'h00000, 1'b1, 1'b0, 8'd0,  20'h00000, 1'b0);
        vecs[3]  = mk(1'b1, 20'h20000, 1'b1, 1'b1, 8'd3,  20'h20000, 1'b0);
        vecs[4]  = mk(1'b1, 20'h20000, 1'b1, 1'b0, 8'd0,  20'h00000, 1'b0);
        vecs[5]  = mk(1'b1, 20'h00006, 1'b1, 1'b1, 8'd5,  20'h00006, 1'b0);
        vecs[6]  = mk(1'b0, 20'h00006, 1'b1, 1'b0, 8'd0,  20'h00000, 1'b0);
        vecs[7]  = mk(1'b0, 20'h00006, 1'b1, 1'b0, 8'd0,  20'h00000, 1'b0);
        vecs[8]  = mk(1'b1, 20'h00001, 1'b0, 1'b1, 8'd8,  20'h00001, 1'b0);
        vecs[9]  = mk(1'b1, 20'h00002, 1'b0, 1'b1, 8'd8,  20'h00001, 1'b0);
        vecs[10] = mk(1'b1, 20'h00003, 1'b0, 1'b1, 8'd8,  20'h00001, 1'b0);
        vecs[11] = mk(1'b1, 20'h00004, 1'b0, 1'b1, 8'd8,  20'h00001, 1'b0);
        vecs[12] = mk(1'b1, 20'h00005, 1'b0, 1'b1, 8'd8,  20'h00001, 1'b1);
        vecs[13] = mk(1'b0, 20'h00005, 1'b1, 1'b1, 8'd9,  20'h00002, 1'b1);
        vecs[14] = mk(1'b0, 20'h00005, 1'b1, 1'b1, 8'd10, 20'h00003, 1'b1);
        vecs[15] = mk(1'b0, 20'h00005, 1'b1, 1'b1, 8'd11, 20'h00004, 1'b1);
        vecs[16] = mk(1'b0, 20'h00005, 1'b1, 1'b0, 8'd0,  20'h00000, 1'b1);

        #3;
        check("rst0_valid", 32'(out_valid), 32'd0);
        check("rst0_data", 32'(out_data), 32'd0);
        check("rst0_stamp", 32'(out_stamp), 32'd0);
        check("rst0_ovf", 32'(overflow), 32'd0);
        check("rst0_sig", 32'(sig), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            step(vecs[i].en, vecs[i].y, vecs[i].rdy);
            check_head($sformatf("vec%0d", i), vecs[i].valid, vecs[i].head, vecs[i].ovf);
        end

        // Mid-run reset with three entries queued, then resample the same word.
        step(1'b1, 20'h0000A, 1'b0);
        step(1'b1, 20'h0000B, 1'b0);
        step(1'b1, 20'h0000C, 1'b0);
        check_head("q3", 1'b1, ent(8'd17, 20'h0000A), 1'b1);
        do_reset("midrst");
        step(1'b1, 20'h0000C, 1'b0);
        check_head("resample", 1'b1, ent(8'd1, 20'h0000C), 1'b0);

        // Fill to four, then push and pop together while full.
        step(1'b1, 20'h0000D, 1'b0);
        step(1'b1, 20'h0000E, 1'b0);
        step(1'b1, 20'h0000F, 1'b0);
        check_head("full", 1'b1, ent(8'd1, 20'h0000C), 1'b0);
        step(1'b1, 20'h00010, 1'b1);
        check_head("pp0", 1'b1, ent(8'd2, 20'h0000D), 1'b0);
        step(1'b0, 20'h00010, 1'b1);
        check_head("pp1", 1'b1, ent(8'd3, 20'h0000E), 1'b0);
        step(1'b0, 20'h00010, 1'b1);
        check_head("pp2", 1'b1, ent(8'd4, 20'h0000F), 1'b0);
        step(1'b0, 20'h00010, 1'b1);
        check_head("pp3", 1'b1, ent(8'd5, 20'h00010), 1'b0);
        step(1'b0, 20'h00010, 1'b1);
        check_head("pp4", 1'b0, ent(8'd0, 20'h00000), 1'b0);

        // Signature: two identical samples, then a hold edge.
        do_reset("misrrst");
        step(1'b1, 20'h00001, 1'b0);
`ifdef E7_RESP_MISR_EN
        check("misr1", 32'(sig), 32'h00001);
`else
        check("misr1", 32'(sig), 32'h00000);
`endif
        step(1'b1, 20'h00001, 1'b0);
`ifdef E7_RESP_MISR_EN
        check("misr2", 32'(sig), 32'h00003);
`else
        check("misr2", 32'(sig), 32'h00000);
`endif
        step(1'b0, 20'h00001, 1'b0);
`ifdef E7_RESP_MISR_EN
        check("misr_hold", 32'(sig), 32'h00003);
`else
        check("misr_hold", 32'(sig), 32'h00000);
`endif
        check_head("misr_q", 1'b1, ent(8'd1, 20'h00001), 1'b0);
        step(1'b0, 20'h00001, 1'b1);
        check_head("misr_drain", 1'b0, ent(8'd0, 20'h00000), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
